seq_right_shifter: RTL
======================

// Module: seq_right_shifter
// PURPOSE
//  Multi-cycle right shifter for the RISC16 ALU; the counterpart to the
//  combinational left barrel shifter.
//  Shifts a WIDTH-bit operand right by shamt, one bit per clock.
//  Supports logical and arithmetic shifts, and rotate when ROTATE_EN is set.
//  Uses a start/busy/done handshake with the execute-stage controller.
//  Trades latency for area on the right-shift path.
// PARAMETERS
//  WIDTH    16  operand/result width in bits
//  SHAMT_W  4   shift-amount width; must equal log2(WIDTH)
// PORTS
//  clk    in   1        rising-edge clock; single clock domain
//  rst_n  in   1        asynchronous, active-low reset
//  start  in   1        request; sampled on rising clk while busy==0
//  din    in   WIDTH    operand, captured with start
//  shamt  in   SHAMT_W  shift amount 0..WIDTH-1, captured with start
//  arith  in   1        1 = arithmetic (sign fill), 0 = logical (zero fill)
//  rot    in   1        1 = rotate right (ROTATE_EN only; else ignored)
//  busy   out  1        high while shifting
//  done   out  1        one-cycle pulse: dout valid
//  dout   out  WIDTH    result, held until the next accepted start
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, busy=0, done=0, dout=0, count=0.
//   - Reset mid-operation aborts the operation; no done pulse follows.
//  FSM states: IDLE, SHIFT, DONE. busy = (state==SHIFT).
//  IDLE/DONE, start=1 at edge N:
//   - capture din into the working register dout.
//   - capture shamt into count, and capture arith/rot.
//   - shamt==0: go to DONE.
//   - shamt!=0: go to SHIFT.
//  IDLE/DONE, start=0: go to IDLE.
//  SHIFT: each edge performs one 1-bit right shift and decrements count.
//   - MSB fill: arith ? dout[WIDTH-1] : 0.
//   - With rot (ROTATE_EN): MSB fill = dout[0]; rot overrides arith.
//   - When count reaches 1 on an edge, the last shift happens and the
//     next state is DONE.
//  DONE: done=1 for exactly one cycle; dout holds the final result.
//  Latency: start at edge N -> done high in cycle after edge N+shamt+1.
//   - shamt=0: done after N+1, with dout=din.
//  Back-to-back: start accepted in DONE; done still pulses that cycle.
//   - dout switches to the new din at the next edge.
//  start while busy: ignored; no queueing; captured operands unchanged.
//  Inputs din/shamt/arith/rot need be stable only at the accepting edge.
//  Outputs are registered; there is no combinational path from input to
//  output.
//  Worst case: shamt=WIDTH-1 -> WIDTH cycles to done.
// CONFIGURATION
//  ROTATE_EN defined: rot input honoured; rotate-right mode available.
//  ROTATE_EN undefined:
//   - rot port present but ignored; no rotate logic synthesised.
//   - rot=1 behaves per arith alone.
// TESTING
//  1. din=16'h0010, shamt=2, arith=0, start pulse ->
//     busy 2 cycles, done 3 cycles after start edge, dout=16'h0004.
//  2. din=16'h8000, shamt=15:
//     arith=1 -> dout=16'hFFFF; arith=0 -> dout=16'h0001;
//     done 16 cycles after start.
//  3. din=16'h1234, shamt=0 -> busy never high; done next cycle;
//     dout=16'h1234.
//  4. din=16'hF000, shamt=4, arith=0; second start (din=16'h00FF) at
//     cycle 2 while busy -> ignored; single done; dout=16'h0F00.
//  5. rst_n low during SHIFT (shamt=8) -> busy=0, done=0, dout=0
//     immediately; no done pulse after release.
//  6. ROTATE_EN: din=16'h0001, shamt=1, rot=1 -> dout=16'h8000;
//     without ROTATE_EN same stimulus -> dout=16'h0000.

Source files
------------

// File: rtl/seq_right_shifter.sv
// Multi-cycle right shifter (logical/arithmetic, one bit per clock) with a start/busy/done handshake.
// Define ROTATE_EN to honour the rot input (rotate right); otherwise rot is ignored.
module seq_right_shifter #(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   din,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               arith,
   input  logic               rot,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   dout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   dout_q;
   logic [SHAMT_W-1:0] count_q;
   logic               arith_q;
   logic               fill_d;
   logic [WIDTH-1:0]   shift_d;

`ifdef ROTATE_EN
   logic               rot_q;
`else
   logic               unused_rot;
   assign unused_rot = rot;
`endif

   // Rotate takes priority over the arithmetic sign fill.
   always_comb begin
      fill_d = arith_q & dout_q[WIDTH-1];
`ifdef ROTATE_EN
      if (rot_q) begin
         fill_d = dout_q[0];
      end
`endif
      shift_d = {fill_d, dout_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dout_q  <= '0;
         count_q <= '0;
         arith_q <= 1'b0;
`ifdef ROTATE_EN
         rot_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  dout_q  <= din;
                  count_q <= shamt;
                  arith_q <= arith;
`ifdef ROTATE_EN
                  rot_q   <= rot;
`endif
                  if (shamt == '0) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= SHIFT;
                     busy_q  <= 1'b1;
                     done_q  <= 1'b0;
                  end
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end
            end
            SHIFT: begin
               dout_q  <= shift_d;
               count_q <= count_q - SHAMT_W'(1);
               if (count_q == SHAMT_W'(1)) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign dout = dout_q;

endmodule
